// File: rtl/pad_frame_ctrl.sv
// Frame sequencer ahead of the padding window generator: validates and holds
// frame config, gates pixels in, forces TLAST, counts windows to completion.
//
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   i_desc_*, o_desc_ready              frame descriptor handshake
//   o_cfg_width/height/pad_en           generator config, held per frame
//   i_s_valid, i_s_last, o_s_ready      upstream pixel handshake
//   o_pad_valid, o_pad_tlast, i_pad_ready  generator input handshake
//   i_win_valid                         generator window strobe
//   o_busy, o_frame_done, o_err_*       status and one-cycle pulses
//   o_frame_cnt                         completed frame count
module pad_frame_ctrl #(
  parameter int MAX_IMG_WIDTH  = 1024,
  parameter int MAX_IMG_HEIGHT = 1024,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_desc_valid,
  input  logic [15:0] i_desc_width,
  input  logic [15:0] i_desc_height,
  input  logic        i_desc_pad_en,
  output logic        o_desc_ready,
  output logic [15:0] o_cfg_width,
  output logic [15:0] o_cfg_height,
  output logic        o_cfg_pad_en,
  input  logic        i_s_valid,
  input  logic        i_s_last,
  output logic        o_s_ready,
  output logic        o_pad_valid,
  output logic        o_pad_tlast,
  input  logic        i_pad_ready,
  input  logic        i_win_valid,
  output logic        o_busy,
  output logic        o_frame_done,
  output logic        o_err_cfg,
  output logic        o_err_len,
  output logic        o_err_timeout,
  output logic [15:0] o_frame_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    STREAM,
    DRAIN,
    DONE
  } state_t;

  localparam logic [15:0] MAX_W = 16'(MAX_IMG_WIDTH);
  localparam logic [15:0] MAX_H = 16'(MAX_IMG_HEIGHT);
  localparam logic [31:0] TMO   = 32'(TIMEOUT_CYCLES);

  state_t state, state_nx;

  logic        settle_q;
  logic [31:0] pix_cnt;
  logic [31:0] win_cnt;
  logic [31:0] wd_cnt;
  logic [31:0] total;
  logic [31:0] expected;

  logic [31:0] dim_w, dim_h;
  logic [31:0] win_nx;
  logic        in_str, in_drn;
  logic        accept, desc_ok, load;
  logic        beat, last_pix, end_beat;
  logic        done_win, wd_fire;

  assign dim_w  = {16'd0, i_desc_width};
  assign dim_h  = {16'd0, i_desc_height};
  assign in_str = (state == STREAM);
  assign in_drn = (state == DRAIN);

  assign accept  = (state == IDLE) && i_desc_valid;
  assign desc_ok = (i_desc_width >= 16'd3) &&
                   (i_desc_width <= MAX_W) &&
                   (i_desc_height >= 16'd3) &&
                   (i_desc_height <= MAX_H);
  assign load    = accept && desc_ok;

  assign beat     = in_str && i_s_valid && i_pad_ready;
  assign last_pix = (pix_cnt == total - 32'd1);
  assign end_beat = beat && (last_pix || i_s_last);

  // A window landing this cycle counts toward completion immediately.
  assign win_nx   = win_cnt + {31'd0, i_win_valid};
  assign done_win = (win_nx >= expected);
  assign wd_fire  = (wd_cnt >= TMO);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (load) state_nx = SETTLE;
      end
      SETTLE: begin
        if (settle_q) state_nx = STREAM;
      end
      STREAM: begin
        if (end_beat) state_nx = DRAIN;
      end
      DRAIN: begin
        if (done_win || wd_fire) state_nx = DONE;
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    o_desc_ready = (state == IDLE);
    o_busy       = (state != IDLE);
    o_s_ready    = in_str && i_pad_ready;
    o_pad_valid  = in_str && i_s_valid;
    o_pad_tlast  = in_str && (last_pix || i_s_last);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_cfg_width   <= '0;
      o_cfg_height  <= '0;
      o_cfg_pad_en  <= 1'b0;
      total         <= '0;
      expected      <= '0;
      settle_q      <= 1'b0;
      pix_cnt       <= '0;
      win_cnt       <= '0;
      wd_cnt        <= '0;
      o_frame_done  <= 1'b0;
      o_err_cfg     <= 1'b0;
      o_err_len     <= 1'b0;
      o_err_timeout <= 1'b0;
      o_frame_cnt   <= '0;
    end else begin
      settle_q      <= (state == SETTLE);
      o_err_cfg     <= accept && !desc_ok;
      // Mismatch either way: early TLAST or missing TLAST on the final pixel.
      o_err_len     <= beat && (last_pix != i_s_last);
      o_err_timeout <= in_drn && !done_win && wd_fire;
      o_frame_done  <= (state_nx == DONE);

      if (load) begin
        o_cfg_width  <= i_desc_width;
        o_cfg_height <= i_desc_height;
        o_cfg_pad_en <= i_desc_pad_en;
        total        <= dim_w * dim_h;
        expected     <= i_desc_pad_en ? dim_w * dim_h
                      : (dim_w - 32'd2) * (dim_h - 32'd2);
        pix_cnt      <= '0;
        win_cnt      <= '0;
      end else begin
        if (beat) pix_cnt <= pix_cnt + 32'd1;
        if ((in_str || in_drn) && i_win_valid) begin
          win_cnt <= win_cnt + 32'd1;
        end
      end

      if (in_drn && !i_win_valid) begin
        wd_cnt <= wd_cnt + 32'd1;
      end else begin
        wd_cnt <= '0;
      end

      if (state == DONE) o_frame_cnt <= o_frame_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pad_frame_ctrl.sv
// Bench for pad_frame_ctrl: frame-level reference model compared every cycle,
// plus literal checks on latencies, beat counts and pulses.
module tb_pad_frame_ctrl;

  localparam int TO = 20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_desc_valid;
  logic [15:0] i_desc_width;
  logic [15:0] i_desc_height;
  logic        i_desc_pad_en;
  logic        o_desc_ready;
  logic [15:0] o_cfg_width;
  logic [15:0] o_cfg_height;
  logic        o_cfg_pad_en;
  logic        i_s_valid;
  logic        i_s_last;
  logic        o_s_ready;
  logic        o_pad_valid;
  logic        o_pad_tlast;
  logic        i_pad_ready;
  logic        i_win_valid;
  logic        o_busy;
  logic        o_frame_done;
  logic        o_err_cfg;
  logic        o_err_len;
  logic        o_err_timeout;
  logic [15:0] o_frame_cnt;

  pad_frame_ctrl #(
    .MAX_IMG_WIDTH (1024),
    .MAX_IMG_HEIGHT(1024),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_desc_valid (i_desc_valid),
    .i_desc_width (i_desc_width),
    .i_desc_height(i_desc_height),
    .i_desc_pad_en(i_desc_pad_en),
    .o_desc_ready (o_desc_ready),
    .o_cfg_width  (o_cfg_width),
    .o_cfg_height (o_cfg_height),
    .o_cfg_pad_en (o_cfg_pad_en),
    .i_s_valid    (i_s_valid),
    .i_s_last     (i_s_last),
    .o_s_ready    (o_s_ready),
    .o_pad_valid  (o_pad_valid),
    .o_pad_tlast  (o_pad_tlast),
    .i_pad_ready  (i_pad_ready),
    .i_win_valid  (i_win_valid),
    .o_busy       (o_busy),
    .o_frame_done (o_frame_done),
    .o_err_cfg    (o_err_cfg),
    .o_err_len    (o_err_len),
    .o_err_timeout(o_err_timeout),
    .o_frame_cnt  (o_frame_cnt)
  );

  always #5 clk = ~clk;

  int n_tot = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  // Reference model: phase 0 idle, 1 settle, 2 stream, 3 drain, 4 done.
  int        m_ph = 0;
  bit        m_set = 0;
  int        m_w = 0, m_h = 0;
  bit        m_pad = 0;
  int        m_pix = 0, m_win = 0, m_idle = 0;
  logic [15:0] m_frames = '0;
  bit        m_ecfg = 0, m_elen = 0, m_eto = 0;

  function automatic bit legal(input int w, input int h);
    return w >= 3 && w <= 1024 && h >= 3 && h <= 1024;
  endfunction

  function automatic int n_win(input int w, input int h, input bit pad);
    return pad ? w * h : (w - 2) * (h - 2);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph <= 0; m_set <= 0; m_w <= 0; m_h <= 0; m_pad <= 0;
      m_pix <= 0; m_win <= 0; m_idle <= 0; m_frames <= '0;
      m_ecfg <= 0; m_elen <= 0; m_eto <= 0;
    end else begin
      m_ecfg <= 0; m_elen <= 0; m_eto <= 0;
      case (m_ph)
        0: if (i_desc_valid) begin
          if (legal(int'(i_desc_width), int'(i_desc_height))) begin
            m_w <= int'(i_desc_width);
            m_h <= int'(i_desc_height);
            m_pad <= i_desc_pad_en;
            m_pix <= 0; m_win <= 0; m_set <= 0; m_ph <= 1;
          end else begin
            m_ecfg <= 1;
          end
        end
        1: begin
          if (m_set) m_ph <= 2;
          m_set <= 1;
        end
        2: begin
          if (i_win_valid) m_win <= m_win + 1;
          if (i_s_valid && i_pad_ready) begin
            m_pix <= m_pix + 1;
            if (m_pix == m_w * m_h - 1 || i_s_last) begin
              m_elen <= (m_pix == m_w * m_h - 1) != i_s_last;
              m_idle <= 0;
              m_ph <= 3;
            end
          end
        end
        3: begin
          m_win <= m_win + int'(i_win_valid);
          m_idle <= i_win_valid ? 0 : m_idle + 1;
          if (m_win + int'(i_win_valid) >= n_win(m_w, m_h, m_pad)) begin
            m_ph <= 4;
          end else if (m_idle >= TO) begin
            m_eto <= 1;
            m_ph <= 4;
          end
        end
        default: begin
          m_frames <= m_frames + 16'd1;
          m_ph <= 0;
        end
      endcase
    end
  end

  logic [57:0] cmp_got, cmp_exp;

  always @(negedge clk) begin
    cmp_exp = {m_ph == 0, 16'(m_w), 16'(m_h), m_pad,
               m_ph == 2 && i_pad_ready, m_ph == 2 && i_s_valid,
               m_ph == 2 && (m_pix == m_w * m_h - 1 || i_s_last),
               m_ph != 0, m_ph == 4, m_ecfg, m_elen, m_eto, m_frames};
    cmp_got = {o_desc_ready, o_cfg_width, o_cfg_height, o_cfg_pad_en,
               o_s_ready, o_pad_valid, o_pad_tlast, o_busy,
               o_frame_done, o_err_cfg, o_err_len, o_err_timeout,
               o_frame_cnt};
    chk("outputs", {6'd0, cmp_got}, {6'd0, cmp_exp});
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int g = 0;
    while (!o_desc_ready && g < 300) begin
      cyc();
      g++;
    end
    if (!o_desc_ready) chk("idle_budget", 64'(g), 64'd0);
  endtask

  task automatic send_desc(input int w, input int h, input bit pad);
    i_desc_valid  = 1'b1;
    i_desc_width  = 16'(w);
    i_desc_height = 16'(h);
    i_desc_pad_en = pad;
    cyc();
    i_desc_valid  = 1'b0;
  endtask

  task automatic run_frame(input int w, input int h, input bit pad,
                           input int last_at, input int rdy_pct,
                           input bit emit, output int beats,
                           output int tl_beat);
    int tot, exp_w, stop, wins, guard;
    tot   = w * h;
    exp_w = n_win(w, h, pad);
    stop  = (last_at > 0 && last_at < tot) ? last_at : tot;
    beats = 0; wins = 0; tl_beat = 0; guard = 0;
    wait_idle();
    send_desc(w, h, pad);
    while (beats < stop && guard < 4000) begin
      guard++;
      i_s_valid   = $urandom_range(3) != 0;
      i_pad_ready = $urandom_range(99) < rdy_pct;
      i_s_last    = (beats == last_at - 1);
      i_win_valid = emit && beats > 0 && wins < exp_w - 1 &&
                    $urandom_range(2) == 0;
      @(negedge clk);
      if (i_win_valid) wins++;
      if (o_s_ready && i_s_valid) begin
        beats++;
        if (o_pad_tlast && tl_beat == 0) tl_beat = beats;
      end
      cyc();
    end
    if (beats < stop) chk("stream_budget", 64'(beats), 64'(stop));
    i_s_last    = 1'b0;
    i_win_valid = 1'b0;
    i_s_valid   = $urandom_range(1);
    if (emit) begin
      guard = 0;
      while (wins < exp_w && guard < 4000) begin
        guard++;
        i_win_valid = $urandom_range(2) != 0;
        if (i_win_valid) wins++;
        cyc();
      end
      i_win_valid = 1'b0;
      @(negedge clk);
      chk("done_lat", 64'(o_frame_done), 64'd1);
      cyc();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_time_limit");
    $fatal(1);
  end

  initial begin
    int beats, tl, n;
    rst_n = 1'b1;
    i_desc_valid = 0; i_desc_width = '0; i_desc_height = '0;
    i_desc_pad_en = 0; i_s_valid = 0; i_s_last = 0;
    i_pad_ready = 0; i_win_valid = 0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_desc_ready", 64'(o_desc_ready), 64'd1);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_cfg", {31'd0, o_cfg_width, o_cfg_height, o_cfg_pad_en}, 64'd0);
    chk("rst_frame_cnt", 64'(o_frame_cnt), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cyc();

    // 4x4 same padding, TLAST on beat 16, 16 windows.
    run_frame(4, 4, 1'b1, 16, 70, 1'b1, beats, tl);
    chk("t1_beats", 64'(beats), 64'd16);
    chk("t1_tlast_beat", 64'(tl), 64'd16);
    @(negedge clk);
    chk("t1_frame_cnt", 64'(o_frame_cnt), 64'd1);
    cyc();

    // 5x5 valid-only: 9 windows, then a stray window in IDLE.
    run_frame(5, 5, 1'b0, 25, 100, 1'b1, beats, tl);
    i_win_valid = 1'b1;
    cyc();
    i_win_valid = 1'b0;
    @(negedge clk);
    chk("t2_idle_busy", 64'(o_busy), 64'd0);
    chk("t2_frame_cnt", 64'(o_frame_cnt), 64'd2);
    cyc();

    // Illegal descriptors leave config alone and never open the gate.
    i_pad_ready = 1'b1;
    send_desc(2, 4, 1'b1);
    @(negedge clk);
    chk("t3_err_cfg_w2", 64'(o_err_cfg), 64'd1);
    chk("t3_cfg_keep", {31'd0, o_cfg_width, o_cfg_height, o_cfg_pad_en},
        {31'd0, 16'd5, 16'd5, 1'b0});
    chk("t3_s_ready", 64'(o_s_ready), 64'd0);
    cyc();
    send_desc(1025, 4, 1'b1);
    @(negedge clk);
    chk("t3_err_cfg_w1025", 64'(o_err_cfg), 64'd1);
    chk("t3_busy", 64'(o_busy), 64'd0);
    cyc();

    // Early TLAST on beat 10, no windows: length error then watchdog.
    run_frame(4, 4, 1'b1, 10, 80, 1'b0, beats, tl);
    chk("t4_beats", 64'(beats), 64'd10);
    chk("t4_tlast_beat", 64'(tl), 64'd10);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) chk("t4_err_len", 64'(o_err_len), 64'd1);
    end while (!o_frame_done && n < 200);
    chk("t4_timeout_lat", 64'(n), 64'(TO + 2));
    chk("t4_err_timeout", 64'(o_err_timeout), 64'd1);
    cyc();

    // 8x3 under heavy backpressure.
    run_frame(8, 3, 1'b1, 24, 40, 1'b1, beats, tl);
    chk("t5_beats", 64'(beats), 64'd24);
    chk("t5_tlast_beat", 64'(tl), 64'd24);
    chk("t5_cfg", {31'd0, o_cfg_width, o_cfg_height, o_cfg_pad_en},
        {31'd0, 16'd8, 16'd3, 1'b1});

    // Reset in the middle of STREAM.
    wait_idle();
    send_desc(4, 4, 1'b1);
    i_s_valid = 1'b1;
    i_pad_ready = 1'b1;
    repeat (5) cyc();
    #2 rst_n = 1'b0;
    #1;
    chk("t6_busy", 64'(o_busy), 64'd0);
    chk("t6_desc_ready", 64'(o_desc_ready), 64'd1);
    chk("t6_s_ready", 64'(o_s_ready), 64'd0);
    chk("t6_cfg", {31'd0, o_cfg_width, o_cfg_height, o_cfg_pad_en}, 64'd0);
    chk("t6_frame_cnt", 64'(o_frame_cnt), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    i_s_valid = 1'b0;
    run_frame(4, 4, 1'b1, 16, 80, 1'b1, beats, tl);
    @(negedge clk);
    chk("t6_after_cnt", 64'(o_frame_cnt), 64'd1);
    cyc();

    // Randomized frames with occasional bad descriptors and bad lengths.
    for (int k = 0; k < 12; k++) begin
      int w, h, la;
      bit pad;
      w = 3 + int'($urandom_range(4));
      h = 3 + int'($urandom_range(4));
      pad = 1'($urandom_range(1));
      case ($urandom_range(3))
        0: la = 0;
        1: la = 1 + int'($urandom_range(w * h - 2));
        default: la = w * h;
      endcase
      if ($urandom_range(2) == 0) begin
        wait_idle();
        send_desc(1 + int'($urandom_range(1)), 3000, 1'b1);
      end
      run_frame(w, h, pad, la, 30 + int'($urandom_range(70)), 1'b1,
                beats, tl);
      chk("rnd_beats", 64'(beats), 64'((la > 0 && la < w * h) ? la : w * h));
    end

    repeat (3) cyc();
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/pad_frame_ctrl.md
# pad_frame_ctrl

Frame sequencer that sits in front of the `padding` window generator. It accepts one frame descriptor at a time (width, height, pad enable), validates it, and drives the generator's configuration ports stable for the whole frame. It gates the upstream pixel stream into the generator and forces TLAST on the final pixel. It counts emitted windows to detect frame completion, with a watchdog that covers a stalled drain.

## Interface
Parameters:
- `MAX_IMG_WIDTH`, 1024: largest legal frame width; must match the generator.
- `MAX_IMG_HEIGHT`, 1024: largest legal frame height.
- `TIMEOUT_CYCLES`, 65535: idle cycles allowed between windows in DRAIN before the frame is aborted.

Ports:
- `clk`  in  1  single clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `i_desc_valid`  in  1  descriptor offered.
- `i_desc_width`  in  16  frame width in pixels.
- `i_desc_height`  in  16  frame height in pixels.
- `i_desc_pad_en`  in  1  1 = same padding, 0 = valid-only windows.
- `o_desc_ready`  out  1  descriptor accepted when high together with valid.
- `o_cfg_width`  out  16  to generator `i_cfg_width`.
- `o_cfg_height`  out  16  to generator `i_cfg_height`.
- `o_cfg_pad_en`  out  1  to generator `i_cfg_pad_en`.
- `i_s_valid`  in  1  upstream pixel valid (data bus is wired directly to the generator, not through this block).
- `i_s_last`  in  1  upstream end-of-frame marker.
- `o_s_ready`  out  1  upstream may advance.
- `o_pad_valid`  out  1  to generator `i_valid`.
- `o_pad_tlast`  out  1  to generator `i_tlast`.
- `i_pad_ready`  in  1  generator `o_ready`.
- `i_win_valid`  in  1  generator `o_valid`; one window per cycle.
- `o_busy`  out  1  high in every state except IDLE.
- `o_frame_done`  out  1  one-cycle pulse at frame completion.
- `o_err_cfg`  out  1  one-cycle pulse when a descriptor is rejected.
- `o_err_len`  out  1  one-cycle pulse when the upstream length mismatches the descriptor.
- `o_err_timeout`  out  1  one-cycle pulse when the watchdog fires.
- `o_frame_cnt`  out  16  completed frames, wraps modulo 2^16.

## Operation
- FSM states: IDLE, SETTLE, STREAM, DRAIN, DONE.
- **IDLE:**
  - `o_desc_ready`=1.
  - On accept, a descriptor with 3 ≤ width ≤ MAX_IMG_WIDTH and 3 ≤ height ≤ MAX_IMG_HEIGHT is latched into the `o_cfg_*` registers, and the block enters SETTLE.
  - Any other descriptor pulses `o_err_cfg`, leaves `o_cfg_*` unchanged, and stays in IDLE.
- **SETTLE:** lasts exactly 2 cycles so the configuration reaches the generator before any pixel. No pixels are passed.
- **STREAM:**
  - `o_s_ready` = `i_pad_ready`; `o_pad_valid` = `i_s_valid` (both combinational, gated by the state).
  - A beat is `i_s_valid && i_pad_ready`. The 32-bit pixel counter `pix_cnt` increments per beat; `total` = W*H (32-bit).
  - `o_pad_tlast` = (`pix_cnt` == `total`-1) || `i_s_last`.
  - On the beat with `pix_cnt` == `total`-1, go to DRAIN. If `i_s_last` is low on that beat, pulse `o_err_len`; the late tail is not accepted.
  - A beat with `i_s_last`=1 and `pix_cnt` < `total`-1 pulses `o_err_len`, is forwarded with TLAST, and goes to DRAIN.
- **Window count:**
  - The 32-bit counter `win_cnt` increments on `i_win_valid` in STREAM and DRAIN.
  - `expected` = pad_en ? W*H : (W-2)*(H-2), computed at descriptor latch.
  - `i_win_valid` in IDLE, SETTLE or DONE is ignored.
- **DRAIN:**
  - `o_s_ready`=0; `o_pad_valid`=0.
  - When `win_cnt` reaches `expected` (including a window landing in this cycle), go to DONE.
  - The watchdog resets to 0 on entry and on every `i_win_valid`, otherwise increments. At `TIMEOUT_CYCLES` it pulses `o_err_timeout` and goes to DONE.
  - If `win_cnt` ≥ `expected` already on entry, go to DONE next cycle.
- **DONE:** one cycle.
  - `o_frame_done`=1; `o_frame_cnt` increments (visible the following cycle).
  - Go to IDLE.
  - `o_cfg_*` hold their values until the next accepted descriptor.
- **Reset mid-frame:** all counters, registers and outputs clear immediately; the state returns to IDLE. Generator state is the integrator's concern.

## Timing
- Reset values: `o_desc_ready`=1 (IDLE); all other outputs 0, including `o_cfg_*`=0 and `o_frame_cnt`=0.
- Descriptor accepted at edge T: `o_cfg_*` are valid after T, SETTLE covers cycles T+1 and T+2, and `o_s_ready` can first be 1 in cycle T+3.
- `o_s_ready`, `o_pad_valid` and `o_pad_tlast` are combinational from state and inputs. All pulse outputs are registered.
- Completion latency: the `i_win_valid` beat that makes `win_cnt` == `expected` is followed by `o_frame_done` in the next cycle.
- Minimum gap between frames: after DONE, IDLE accepts a descriptor in the first IDLE cycle.

## Test plan
- 4×4 frame, pad_en=1, 16 beats with `i_s_last` on the 16th, generator returns 16 windows → TLAST on beat 16, `o_frame_done` one cycle after window 16, `o_frame_cnt`=1, no errors.
- 5×5 frame, pad_en=0, 9 windows → done after the 9th window; a 10th window arriving in IDLE is ignored.
- Descriptor width=2 or width=1025 → `o_err_cfg` pulse, `o_cfg_*` unchanged, `o_busy`=0, `o_s_ready` stays 0.
- 4×4 frame with `i_s_last` on beat 10 → `o_err_len`, forced TLAST on beat 10, no windows afterwards, `o_err_timeout` after `TIMEOUT_CYCLES`, then `o_frame_done`.
- Random `i_pad_ready` backpressure on a 8×3 frame → exactly 24 beats; `o_s_ready` tracks `i_pad_ready` only in STREAM; the `o_cfg_*` values are stable throughout.
- `rst_n` asserted during STREAM → all outputs return to reset values within the same cycle; a new descriptor is accepted normally afterwards.
